// File: rtl/key_pkg.sv
// Shared types and defaults for the six-channel push-button debouncer.
package key_pkg;

   localparam int KEY_CH            = 6;
   localparam int DB_CYCLES_DEF     = 200000;
   localparam int REPEAT_DELAY_DEF  = 10000000;
   localparam int REPEAT_PERIOD_DEF = 2000000;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_e;

   // A counter that tops out at n-1 needs $clog2(n) bits, but never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Button bundle: raw levels in, debounced level and press/release pulses out.
interface key_debounce_if;
   import key_pkg::*;

   logic [KEY_CH-1:0] swb_raw;
   logic [KEY_CH-1:0] swb_level;
   logic [KEY_CH-1:0] swb_press;
   logic [KEY_CH-1:0] swb_release;

   modport master (
      output swb_raw,
      input  swb_level,
      input  swb_press,
      input  swb_release
   );

   modport slave (
      input  swb_raw,
      output swb_level,
      output swb_press,
      output swb_release
   );

endinterface

// File: rtl/key_channel.sv
// One button: 2-FF synchronizer, debounce FSM, optional auto-repeat (BTN_REPEAT_EN).
// Pulses land DB_CYCLES+2 clocks after the first edge sampling a clean level; no backpressure.
module key_channel
   import key_pkg::*;
#(
   parameter int DB_CYCLES     = DB_CYCLES_DEF,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel
);

   localparam int CNT_W = cnt_width(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic [1:0]       sync;
   logic             din;
   key_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic             cnt_done;
   logic             rpt_fire;

   assign din      = sync[1];
   assign cnt_done = (cnt == CNT_MAX);

`ifdef BTN_REPEAT_EN
   localparam int RPT_MAX_VAL = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W = cnt_width(RPT_MAX_VAL);
   localparam logic [RPT_W-1:0] RPT_DLY_MAX = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_PER_MAX = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic             rpt_phase;   // 0: waiting out the initial delay, 1: periodic repeats

   assign rpt_fire = (state == HELD) && din &&
                     (rpt_cnt == (rpt_phase ? RPT_PER_MAX : RPT_DLY_MAX));

   // Any exit from HELD (including a release glitch) restarts the initial delay.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rpt_cnt   <= '0;
         rpt_phase <= 1'b0;
      end else if ((state != HELD) || !din) begin
         rpt_cnt   <= '0;
         rpt_phase <= 1'b0;
      end else if (rpt_fire) begin
         rpt_cnt   <= '0;
         rpt_phase <= 1'b1;
      end else begin
         rpt_cnt   <= rpt_cnt + 1'b1;
      end
   end
`else
   localparam int unused_rpt_cfg = REPEAT_DELAY + REPEAT_PERIOD;
   assign rpt_fire = 1'b0;
`endif

   // The counter only advances while below CNT_MAX; reaching it always changes state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= 2'b00;
         state <= IDLE;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         sync  <= {sync[0], raw};
         press <= 1'b0;
         rel   <= 1'b0;
         case (state)
            IDLE: begin
               if (din) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!din) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt_done) begin
                  state <= HELD;
                  cnt   <= '0;
                  level <= 1'b1;
                  press <= 1'b1;
               end else begin
                  cnt   <= cnt + 1'b1;
               end
            end
            HELD: begin
               if (!din) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end else if (rpt_fire) begin
                  press <= 1'b1;
               end
            end
            RELEASE_WAIT: begin
               if (din) begin
                  state <= HELD;
                  cnt   <= '0;
               end else if (cnt_done) begin
                  state <= IDLE;
                  cnt   <= '0;
                  level <= 1'b0;
                  rel   <= 1'b1;
               end else begin
                  cnt   <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_debounce.sv
// Six independent debounced buttons; auto-repeat on press when BTN_REPEAT_EN is defined.
// Pulses land DB_CYCLES+2 clocks after a clean edge is first sampled; no backpressure.
module key_debounce
   import key_pkg::*;
#(
   parameter int DB_CYCLES     = DB_CYCLES_DEF,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic           clk,
   input  logic           rst,
   key_debounce_if.slave  swb
);

   logic [KEY_CH-1:0] level_w;
   logic [KEY_CH-1:0] press_w;
   logic [KEY_CH-1:0] rel_w;

   for (genvar i = 0; i < KEY_CH; i++) begin : g_ch
      key_channel #(
         .DB_CYCLES     (DB_CYCLES),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .raw   (swb.swb_raw[i]),
         .level (level_w[i]),
         .press (press_w[i]),
         .rel   (rel_w[i])
      );
   end

   assign swb.swb_level   = level_w;
   assign swb.swb_press   = press_w;
   assign swb.swb_release = rel_w;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.
module tb_key_debounce;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   key_debounce_if swb_if ();

   key_debounce #(
      .DB_CYCLES     (4),
      .REPEAT_DELAY  (20),
      .REPEAT_PERIOD (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .swb (swb_if)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Raw level was just changed; expect nothing for 6 edges, then the pulse on the 7th.
   task automatic expect_pulse(input string tag, input logic [5:0] p, input logic [5:0] r);
      for (int i = 0; i < 6; i++) begin
         step();
         chk({tag, "_early_press"}, swb_if.swb_press, 6'b0);
         chk({tag, "_early_rel"}, swb_if.swb_release, 6'b0);
      end
      step();
      chk({tag, "_press"}, swb_if.swb_press, p);
      chk({tag, "_rel"}, swb_if.swb_release, r);
      step();
      chk({tag, "_after_press"}, swb_if.swb_press, 6'b0);
      chk({tag, "_after_rel"}, swb_if.swb_release, 6'b0);
   endtask

   initial begin
      logic [5:0] exp_p;
      swb_if.swb_raw = 6'b0;

      // Reset state
      step();
      chk("rst_level", swb_if.swb_level, 6'b0);
      chk("rst_press", swb_if.swb_press, 6'b0);
      chk("rst_rel", swb_if.swb_release, 6'b0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_level", swb_if.swb_level, 6'b0);
         chk("idle_press", swb_if.swb_press, 6'b0);
      end

      // Clean press and release on channel 0
      swb_if.swb_raw = 6'b000001;
      expect_pulse("clean_press", 6'b000001, 6'b0);
      chk("clean_level_hi", swb_if.swb_level, 6'b000001);
      swb_if.swb_raw = 6'b0;
      expect_pulse("clean_rel", 6'b0, 6'b000001);
      chk("clean_level_lo", swb_if.swb_level, 6'b0);

      // Bounce on channel 2: 1,0,1,0 for two cycles each, then hold
      for (int b = 0; b < 4; b++) begin
         swb_if.swb_raw = (b % 2 == 0) ? 6'b000100 : 6'b000000;
         for (int i = 0; i < 2; i++) begin
            step();
            chk("bounce_press", swb_if.swb_press, 6'b0);
            chk("bounce_level", swb_if.swb_level, 6'b0);
         end
      end
      swb_if.swb_raw = 6'b000100;
      expect_pulse("bounce_final", 6'b000100, 6'b0);
      chk("bounce_level_hi", swb_if.swb_level, 6'b000100);
      swb_if.swb_raw = 6'b0;
      expect_pulse("bounce_rel", 6'b0, 6'b000100);

      // Release glitch on channel 1: 3 low cycles must not release
      swb_if.swb_raw = 6'b000010;
      expect_pulse("glitch_press", 6'b000010, 6'b0);
      swb_if.swb_raw = 6'b0;
      for (int i = 0; i < 3; i++) step();
      swb_if.swb_raw = 6'b000010;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("glitch_rel", swb_if.swb_release, 6'b0);
         chk("glitch_level", swb_if.swb_level, 6'b000010);
      end
      swb_if.swb_raw = 6'b0;
      expect_pulse("glitch_final_rel", 6'b0, 6'b000010);

      // Hold channel 3: repeats at acceptance+20, then every 5 (only with BTN_REPEAT_EN)
      swb_if.swb_raw = 6'b001000;
      for (int i = 0; i < 6; i++) step();
      step();
      chk("rpt_accept", swb_if.swb_press, 6'b001000);
      for (int s = 1; s <= 50; s++) begin
         step();
`ifdef BTN_REPEAT_EN
         exp_p = (s >= 20 && (s - 20) % 5 == 0) ? 6'b001000 : 6'b0;
`else
         exp_p = 6'b0;
`endif
         chk("rpt_hold", swb_if.swb_press, exp_p);
      end
      swb_if.swb_raw = 6'b0;
      expect_pulse("rpt_rel", 6'b0, 6'b001000);

      // Reset two cycles into PRESS_WAIT on channel 4
      swb_if.swb_raw = 6'b010000;
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      #1;
      chk("midrst_level", swb_if.swb_level, 6'b0);
      chk("midrst_press", swb_if.swb_press, 6'b0);
      chk("midrst_rel", swb_if.swb_release, 6'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("midrst_hold_level", swb_if.swb_level, 6'b0);
         chk("midrst_hold_press", swb_if.swb_press, 6'b0);
      end
      rst = 1'b0;
      expect_pulse("midrst_press_after", 6'b010000, 6'b0);
      chk("midrst_level_hi", swb_if.swb_level, 6'b010000);
      swb_if.swb_raw = 6'b0;
      expect_pulse("midrst_rel_after", 6'b0, 6'b010000);

      // All six keys together
      swb_if.swb_raw = 6'b111111;
      expect_pulse("multi_press", 6'b111111, 6'b0);
      chk("multi_level_hi", swb_if.swb_level, 6'b111111);
      swb_if.swb_raw = 6'b0;
      expect_pulse("multi_rel", 6'b0, 6'b111111);
      chk("multi_level_lo", swb_if.swb_level, 6'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DB_CYCLES, default 200000: number of stable synchronized cycles required to accept a level change (10 ms at 20 MHz).
REQ-002 Parameter REPEAT_DELAY, default 10000000: number of held cycles after an accepted press before the first auto-repeat pulse (0.5 s).
REQ-003 Parameter REPEAT_PERIOD, default 2000000: number of cycles between successive auto-repeat pulses (0.1 s).
REQ-004 clk  input  1  system clock, 20 MHz.
REQ-005 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 swb_raw  input  6  raw push-button levels, asynchronous to clk, 1 = pressed.
REQ-007 swb_level  output  6  debounced button levels.
REQ-008 swb_press  output  6  one-cycle pulse per accepted press, plus auto-repeat pulses when enabled.
REQ-009 swb_release  output  6  one-cycle pulse per accepted release.

Function
REQ-010 Each bit SHALL pass through its own 2-FF synchronizer before any other logic; the six channels SHALL be fully independent.
REQ-011 Each channel SHALL implement an FSM with states IDLE (stable released), PRESS_WAIT, HELD (stable pressed) and RELEASE_WAIT.
REQ-012 IDLE -> PRESS_WAIT when the synchronized input is 1; the stability counter is cleared.
REQ-013 PRESS_WAIT: the counter increments each cycle the input is 1; a single 0 sample SHALL return the channel to IDLE with the counter cleared.
REQ-014 PRESS_WAIT -> HELD when the counter reaches DB_CYCLES-1 with the input still 1; swb_press pulses high for exactly that transition cycle, and swb_level rises in the same cycle.
REQ-015 HELD -> RELEASE_WAIT when the input is 0; RELEASE_WAIT mirrors PRESS_WAIT with the polarity inverted (a 1 sample returns to HELD).
REQ-016 RELEASE_WAIT -> IDLE fires swb_release for one cycle, and swb_level falls in the same cycle.
REQ-017 Latency: for a clean edge, the pulse SHALL occur exactly DB_CYCLES+2 clock cycles after the first rising clk edge that samples the new raw level.
REQ-018 Stability counters SHALL be sized to $clog2 of the largest counted value and SHALL saturate, never wrap; DB_CYCLES=1 SHALL accept a change after one synchronized sample.
REQ-019 Simultaneous presses on several channels SHALL produce simultaneous pulses; there is no arbitration.
REQ-020 swb_press and swb_release SHALL never both be high on one channel in the same cycle.

Reset
REQ-021 While rst is high, all channels SHALL be in IDLE, counters and synchronizers SHALL be 0, and swb_level, swb_press and swb_release SHALL be 0.
REQ-022 A button held through reset deassertion SHALL be treated as a new press, with swb_press pulsing DB_CYCLES+2 cycles after rst falls.
REQ-023 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse emitted.

Configuration
REQ-024 Macro BTN_REPEAT_EN defined: in HELD, a repeat counter runs; swb_press pulses once after REPEAT_DELAY held cycles and then every REPEAT_PERIOD cycles until the channel leaves HELD.
REQ-025 Leaving HELD SHALL clear the repeat counter, so a re-entry into HELD from RELEASE_WAIT restarts the REPEAT_DELAY count.
REQ-026 Macro BTN_REPEAT_EN undefined: there is no repeat counter logic, and exactly one swb_press pulse is produced per accepted press.

Structure
REQ-027 A shared package key_pkg SHALL hold the channel-state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), the channel count of 6, and the default timing constants.
REQ-028 A single-channel sub-module key_channel (synchronizer, FSM and counters) SHALL be instantiated 6 times by a generate loop in key_debounce.

Verification (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-029 Clean press: swb_raw[0] goes 0->1 and is held -> swb_press[0] pulses once, 6 cycles after the first sampling edge, and swb_level[0] goes to 1.
REQ-030 Bounce: swb_raw[2] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no pulse during the bounce, then a single swb_press[2] 6 cycles after the final rise.
REQ-031 Release glitch: with swb_raw[1] held, drive 0 for 3 cycles then back to 1 -> no swb_release[1], and swb_level[1] stays 1.
REQ-032 Auto-repeat (BTN_REPEAT_EN defined): hold swb_raw[3] for 60 cycles -> swb_press[3] pulses at acceptance, at acceptance+20, and then every 5 cycles; with the macro undefined -> one pulse only.
REQ-033 Reset mid-debounce: assert rst 2 cycles into PRESS_WAIT with swb_raw[4]=1 held -> all outputs 0 during reset, and swb_press[4] pulses 6 cycles after rst falls.
REQ-034 Multi-key: swb_raw=6'b111111 applied in one cycle -> swb_press=6'b111111 for one cycle; releasing all -> swb_release=6'b111111 for one cycle.
